// File: rtl/bp_lce_req_arbiter_if.sv
// Bundles the two LCE request inputs, the arbitrated output link and the
// credit return path that connect to bp_lce_req_arbiter.
interface bp_lce_req_arbiter_if #(
    parameter int req_width_p = 128
);
    logic [1:0][req_width_p-1:0] lce_req_i;
    logic [1:0]                  lce_req_v_i;
    logic [1:0]                  lce_req_ready_o;
    logic [req_width_p-1:0]      lce_req_o;
    logic                        lce_req_v_o;
    logic                        lce_req_ready_i;
    logic                        grant_id_o;
    logic                        credit_return_i;
    logic                        credits_full_o;
    logic                        credits_empty_o;
    logic                        credit_underflow_o;

    // Handshakes on both sides are valid/ready: a transfer happens on a clock
    // edge where valid and ready are both high; a sender that raised valid
    // keeps valid and its payload stable until that edge.
    modport slave (
        input  lce_req_i, lce_req_v_i, lce_req_ready_i, credit_return_i,
        output lce_req_ready_o, lce_req_o, lce_req_v_o, grant_id_o,
               credits_full_o, credits_empty_o, credit_underflow_o
    );

    modport master (
        output lce_req_i, lce_req_v_i, lce_req_ready_i, credit_return_i,
        input  lce_req_ready_o, lce_req_o, lce_req_v_o, grant_id_o,
               credits_full_o, credits_empty_o, credit_underflow_o
    );
endinterface

// File: rtl/bp_lce_req_arbiter.sv
// Round-robin arbiter sharing one credit-limited LCE request link between the
// icache (port 0) and dcache (port 1). Define BP_LCE_REQ_ARB_PERF_EN for perf counters.
module bp_lce_req_arbiter #(
    parameter int req_width_p   = 128,
    parameter int max_credits_p = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    bp_lce_req_arbiter_if.slave    bus_if,
    output logic                   dbg_lock_state_o
`ifdef BP_LCE_REQ_ARB_PERF_EN
    ,
    output logic [1:0][31:0]       perf_grant_o,
    output logic [31:0]            perf_stall_o
`endif
);

    localparam int credit_width_lp = ((max_credits_p + 1) <= 1) ? 1 : $clog2(max_credits_p + 1);
    localparam logic [credit_width_lp-1:0] max_count_lp = credit_width_lp'(max_credits_p);

    typedef enum logic {
        LOCK_OPEN = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

    lock_state_e                 state_q, state_d;
    logic [1:0]                  buf_v_q, buf_v_d;
    logic [1:0][req_width_p-1:0] buf_q, buf_d;
    logic                        last_grant_q, last_grant_d;
    logic                        locked_id_q, locked_id_d;
    logic [credit_width_lp-1:0]  count_q, count_d;
    logic                        underflow_q, underflow_d;

    logic       sel;
    logic       credits_full;
    logic       req_v;
    logic       handshake;
    logic [1:0] ready;

    assign credits_full = (count_q == max_count_lp);
    assign ready        = {2{reset_n_i}} & ~buf_v_q;

    // Selection depends on registers only, so grant_id_o never depends on lce_req_ready_i.
    always_comb begin
        sel = last_grant_q;
        if (state_q == LOCK_HELD) begin
            sel = locked_id_q;
        end else begin
            case (buf_v_q)
                2'b01:   sel = 1'b0;
                2'b10:   sel = 1'b1;
                2'b11:   sel = ~last_grant_q;
                default: sel = last_grant_q;
            endcase
        end
    end

    assign req_v     = reset_n_i & buf_v_q[sel] & ~credits_full;
    assign handshake = req_v & bus_if.lce_req_ready_i;

    always_comb begin
        state_d      = state_q;
        buf_v_d      = buf_v_q;
        buf_d        = buf_q;
        last_grant_d = last_grant_q;
        locked_id_d  = locked_id_q;
        count_d      = count_q;
        underflow_d  = underflow_q;

        if (req_v && !bus_if.lce_req_ready_i) begin
            state_d     = LOCK_HELD;
            locked_id_d = sel;
        end
        if (handshake) begin
            state_d       = LOCK_OPEN;
            last_grant_d  = sel;
            buf_v_d[sel]  = 1'b0;
        end

        // A port is only ready while its buffer is empty, so capture never
        // collides with the drain of the same buffer.
        for (int i = 0; i < 2; i++) begin
            if (bus_if.lce_req_v_i[i] && ready[i]) begin
                buf_v_d[i] = 1'b1;
                buf_d[i]   = bus_if.lce_req_i[i];
            end
        end

        case ({handshake, bus_if.credit_return_i})
            2'b10: count_d = count_q + 1'b1;
            2'b01: begin
                if (count_q == '0) begin
                    underflow_d = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= LOCK_OPEN;
            buf_v_q      <= 2'b00;
            last_grant_q <= 1'b1;
            locked_id_q  <= 1'b0;
            count_q      <= '0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_v_q      <= buf_v_d;
            last_grant_q <= last_grant_d;
            locked_id_q  <= locked_id_d;
            count_q      <= count_d;
            underflow_q  <= underflow_d;
        end
    end

    // Payload needs no reset: it is only observed behind buf_v_q.
    always_ff @(posedge clk_i) begin
        buf_q <= buf_d;
    end

    assign bus_if.lce_req_ready_o    = ready;
    assign bus_if.lce_req_o          = buf_q[sel];
    assign bus_if.lce_req_v_o        = req_v;
    assign bus_if.grant_id_o         = sel;
    assign bus_if.credits_full_o     = credits_full;
    assign bus_if.credits_empty_o    = (count_q == '0);
    assign bus_if.credit_underflow_o = underflow_q;
    assign dbg_lock_state_o          = state_q;

`ifdef BP_LCE_REQ_ARB_PERF_EN
    logic [1:0][31:0] perf_grant_q, perf_grant_d;
    logic [31:0]      perf_stall_q, perf_stall_d;

    always_comb begin
        perf_grant_d = perf_grant_q;
        perf_stall_d = perf_stall_q;
        for (int i = 0; i < 2; i++) begin
            if (handshake && (sel == 1'(i)) && (perf_grant_q[i] != 32'hFFFF_FFFF)) begin
                perf_grant_d[i] = perf_grant_q[i] + 32'd1;
            end
        end
        // With any buffer valid and no lock pending, only a full credit pool blocks valid.
        if ((|buf_v_q) && credits_full && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            perf_grant_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_grant_q <= perf_grant_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_grant_o = perf_grant_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule
